// File: rtl/uart_pkg.sv
// Shared UART constants and the TX arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int CLK_FREQ     = 27_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_LOCKED    = 3'd4
    } arb_state_t;

    // Width of a saturating counter that must be able to hold max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set bit of req_i strictly after ptr_i, wrapping.
// The requester at ptr_i itself is considered last, so a just-served source
// has the lowest priority.
module rr_priority_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    // Scan N positions starting one past the pointer; keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte sources. Round-robin between
// packets; a source that sends a byte with last=0 keeps the transmitter
// until its last byte or until it stalls for LOCK_TO cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int START_TO = 16,
    parameter int LOCK_TO  = 27000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_ready,
    output logic                           tx_valid,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_lock_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = cnt_w(START_TO);
    localparam int LW = cnt_w(LOCK_TO);

    localparam logic [SW-1:0] SCNT_MAX  = SW'(START_TO);
    localparam logic [SW-1:0] SCNT_LAST = SW'(START_TO - 1);
    localparam logic [LW-1:0] LCNT_MAX  = LW'(LOCK_TO);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LOCK_TO - 1);

    arb_state_t               state_q, state_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic                     lock_q, lock_d;
    logic [SW-1:0]            scnt_q, scnt_d;
    logic [LW-1:0]            lcnt_q, lcnt_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [UART_DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                     busy_q, busy_d;
    logic                     lto_q, lto_d;

    logic [NUM_REQ-1:0]       pick_oh;
    logic [IW-1:0]            pick_idx;
    logic                     pick_any;
    logic [IW-1:0]            sel_idx;
    logic [UART_DATA_W-1:0]   sel_data;
    logic                     sel_last;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Byte/last mux: the locked owner (held in the pointer) or the new pick.
    always_comb begin
        sel_idx  = (state_q == ST_LOCKED) ? ptr_q : pick_idx;
        sel_data = req_data[UART_DATA_W*int'(sel_idx) +: UART_DATA_W];
        sel_last = req_last[sel_idx];
    end

    // Next-state and registered-output logic; every ISSUE entry requires tx_ready.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        scnt_d      = '0;
        lcnt_d      = '0;
        grant_d     = grant_q;
        req_ready_d = '0;
        tx_valid_d  = 1'b0;
        tx_data_d   = tx_data_q;
        lto_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (tx_ready && pick_any) begin
                    state_d     = ST_ISSUE;
                    grant_d     = pick_oh;
                    ptr_d       = pick_idx;
                    req_ready_d = pick_oh;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = sel_data;
                    lock_d      = ~sel_last;
                end
            end

            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                // A transmitter that never reports busy must not hang us.
                if (!tx_ready || scnt_q >= SCNT_LAST) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    scnt_d = (scnt_q == SCNT_MAX) ? scnt_q : scnt_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (lock_q) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end

            ST_LOCKED: begin
                if (req_valid[ptr_q] && tx_ready) begin
                    state_d     = ST_ISSUE;
                    req_ready_d = grant_q;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = sel_data;
                    lock_d      = ~sel_last;
                end else if (lcnt_q >= LCNT_LAST) begin
                    // Owner stalled mid-packet too long: revoke the lock.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    lto_d   = 1'b1;
                    lock_d  = 1'b0;
                end else begin
                    lcnt_d = (lcnt_q == LCNT_MAX) ? lcnt_q : lcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                lock_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            lock_q      <= 1'b0;
            scnt_q      <= '0;
            lcnt_q      <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            lto_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            scnt_q      <= scnt_d;
            lcnt_q      <= lcnt_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            lto_q       <= lto_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign o_grant        = grant_q;
    assign o_busy         = busy_q;
    assign o_lock_timeout = lto_q;

endmodule
